// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a received byte; even or odd selected by parity_type_i.
// Instantiated only when UART_RX_PARITY_EN is defined.
module uart_parity_calc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              parity_type_i,
    output logic              parity_o
);

    assign parity_o = (^data_i) ^ parity_type_i;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start detect, mid-bit sampling, optional parity, stop check.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames; undefined gives 8N1 with parity_err_o tied low.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              parity_type_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    rx_state_t         state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              parity_err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_s_q    <= IDLE_LEVEL;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic ptype_q;
    logic par_bit_q;
    logic par_exp;

    uart_parity_calc #(
        .DATA_W(DATA_W)
    ) u_parity_calc (
        .data_i       (shift_q),
        .parity_type_i(ptype_q),
        .parity_o     (par_exp)
    );

    assign parity_err_d = (par_bit_q != par_exp);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptype_q   <= PARITY_EVEN;
            par_bit_q <= 1'b0;
        end else begin
            if (state_q == IDLE && rx_s_q == 1'b0) begin
                ptype_q <= parity_type_i;
            end
            if (state_q == PARITY && cnt_q == CntLast) begin
                par_bit_q <= rx_s_q;
            end
        end
    end
`else
    logic unused_parity_type;
    assign unused_parity_type = parity_type_i;
    assign parity_err_d       = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (rx_s_q == 1'b0) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (rx_s_q == IDLE_LEVEL) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[DATA_W-1:1]};
                        if (bit_idx_q == IdxLast) begin
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit still delivers the byte; IDLE re-arms on the low level.
                    if (cnt_q == CntLast) begin
                        cnt_q        <= '0;
                        data_valid_q <= 1'b1;
                        data_out_q   <= shift_q;
                        parity_err_q <= parity_err_d;
                        frame_err_q  <= ~rx_s_q;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

endmodule
